// File: rtl/uart_word_bridge.sv
// Purpose: packs UART RX bytes into little-endian words and serialises TX words into UART bytes.
// Latency: RX word valid 1 clk after the last byte tick; TX first start 1 clk after accept, next start 1 clk after each done tick.
// Backpressure: none on RX (o_word must be taken on o_word_valid); TX requests arriving while o_tx_busy is high are dropped, not queued.
//
// Ports:
//   i_clock, i_reset        rising-edge clock, asynchronous active-low reset
//   i_rx_data/_done_tick    byte stream from the UART receiver
//   o_word/_valid           last completed RX word and its one-cycle update strobe
//   o_rx_timeout            one-cycle strobe when a partial RX word is discarded
//   i_tx_word/_valid        word to send and its request strobe
//   o_tx_busy               high from the start pulse of the first byte until the word is finished
//   o_tx_data/_start        byte and one-cycle start pulse to the UART transmitter
//   i_tx_done_tick          UART transmitter finished the current byte
//   o_tx_word_done          one-cycle strobe after the last byte of a word
module uart_word_bridge #(
  parameter int NB_DATA        = 8,
  parameter int NB_WORD        = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done_tick,
  output logic [NB_WORD-1:0] o_word,
  output logic               o_word_valid,
  output logic               o_rx_timeout,
  input  logic [NB_WORD-1:0] i_tx_word,
  input  logic               i_tx_word_valid,
  output logic               o_tx_busy,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done_tick,
  output logic               o_tx_word_done
);

  localparam int N_BYTES = NB_WORD / NB_DATA;
  localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BYTES - 1);
  // The counter expires on the edge where it would reach TIMEOUT_CYCLES,
  // so the strobe appears exactly TIMEOUT_CYCLES clocks after the last byte.
  localparam logic [TO_W-1:0]  TO_LAST  = TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  // ---------------------------------------------------------------- RX packer
  logic [CNT_W-1:0]   rx_cnt;
  logic [NB_WORD-1:0] rx_buf;
  logic [NB_WORD-1:0] rx_assembled;
  logic [TO_W-1:0]    to_cnt;
  logic               rx_last;
  logic               to_expire;

  // Current partial word with the incoming byte dropped into its slot.
  always_comb begin
    rx_assembled = rx_buf;
    rx_assembled[rx_cnt*NB_DATA +: NB_DATA] = i_rx_data;
  end

  assign rx_last   = (rx_cnt == CNT_LAST);
  assign to_expire = TO_EN && (rx_cnt != '0) && (to_cnt == TO_LAST);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_cnt       <= '0;
      rx_buf       <= '0;
      to_cnt       <= '0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
      o_rx_timeout <= 1'b0;
    end else begin
      o_word_valid <= 1'b0;
      o_rx_timeout <= 1'b0;
      // A byte tick takes priority over a coinciding timeout expiry.
      if (i_rx_done_tick) begin
        to_cnt <= '0;
        if (rx_last) begin
          rx_cnt       <= '0;
          o_word       <= rx_assembled;
          o_word_valid <= 1'b1;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
          rx_buf <= rx_assembled;
        end
      end else if (to_expire) begin
        rx_cnt       <= '0;
        to_cnt       <= '0;
        o_rx_timeout <= 1'b1;
      end else if (TO_EN && (rx_cnt != '0)) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------- TX serialiser
  typedef enum logic [1:0] {IDLE, SEND, WAIT} tx_state_t;

  tx_state_t          state, state_nxt;
  logic [NB_WORD-1:0] tx_shift, tx_shift_nxt, tx_shifted;
  logic [CNT_W-1:0]   tx_idx, tx_idx_nxt;
  logic [NB_DATA-1:0] tx_data_nxt;
  logic               tx_start_nxt;
  logic               tx_done_nxt;

  assign tx_shifted = tx_shift >> NB_DATA;
  // Busy is taken from the state register so it stays glitch-free and is
  // cleanly zero in reset; it rises together with the first start pulse.
  assign o_tx_busy  = (state != IDLE);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state          <= IDLE;
      tx_shift       <= '0;
      tx_idx         <= '0;
      o_tx_data      <= '0;
      o_tx_start     <= 1'b0;
      o_tx_word_done <= 1'b0;
    end else begin
      state          <= state_nxt;
      tx_shift       <= tx_shift_nxt;
      tx_idx         <= tx_idx_nxt;
      o_tx_data      <= tx_data_nxt;
      o_tx_start     <= tx_start_nxt;
      o_tx_word_done <= tx_done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tx_shift_nxt = tx_shift;
    tx_idx_nxt   = tx_idx;
    tx_data_nxt  = o_tx_data;
    tx_start_nxt = 1'b0;
    tx_done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_tx_word_valid) begin
          tx_shift_nxt = i_tx_word;
          tx_idx_nxt   = '0;
          tx_data_nxt  = i_tx_word[NB_DATA-1:0];
          tx_start_nxt = 1'b1;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (i_tx_done_tick) begin
          if (tx_idx == CNT_LAST) begin
            tx_done_nxt = 1'b1;
            state_nxt   = IDLE;
          end else begin
            tx_shift_nxt = tx_shifted;
            tx_idx_nxt   = tx_idx + 1'b1;
            tx_data_nxt  = tx_shifted[NB_DATA-1:0];
            tx_start_nxt = 1'b1;
            state_nxt    = SEND;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_word_bridge.sv
// Purpose: scoreboard bench for uart_word_bridge with TIMEOUT_CYCLES=100.
// Latency: expectations carry the exact cycle each output strobe must appear in.
// Backpressure: a responder returns i_tx_done_tick 20 cycles after every start pulse.
module tb_uart_word_bridge;

  localparam int NB_DATA = 8;
  localparam int NB_WORD = 32;
  localparam int TO      = 100;

  logic               i_clock = 1'b0;
  logic               i_reset = 1'b0;
  logic [NB_DATA-1:0] i_rx_data = '0;
  logic               i_rx_done_tick = 1'b0;
  logic [NB_WORD-1:0] o_word;
  logic               o_word_valid;
  logic               o_rx_timeout;
  logic [NB_WORD-1:0] i_tx_word = '0;
  logic               i_tx_word_valid = 1'b0;
  logic               o_tx_busy;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done_tick = 1'b0;
  logic               o_tx_word_done;

  uart_word_bridge #(
    .NB_DATA(NB_DATA), .NB_WORD(NB_WORD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_done_tick(i_rx_done_tick),
    .o_word(o_word), .o_word_valid(o_word_valid), .o_rx_timeout(o_rx_timeout),
    .i_tx_word(i_tx_word), .i_tx_word_valid(i_tx_word_valid), .o_tx_busy(o_tx_busy),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .i_tx_done_tick(i_tx_done_tick), .o_tx_word_done(o_tx_word_done)
  );

  initial forever #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] val;
    int          cyc;   // -1: must coincide with the most recent done tick
  } exp_t;

  exp_t q_word[$], q_to[$], q_tx[$], q_wd[$];
  exp_t mon_e;
  int n_checks = 0;
  int n_fail = 0;
  int last_done_cyc = 0;
  int rst_gen = 0;

  function automatic exp_t mk(input logic [31:0] v, input int c);
    exp_t e;
    e.val = v;
    e.cyc = c;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: pulse at cycle %0d with no expected entry", name, cyc);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_o_word"}, o_word, 0);
    chk({tag, "_o_word_valid"}, o_word_valid, 0);
    chk({tag, "_o_rx_timeout"}, o_rx_timeout, 0);
    chk({tag, "_o_tx_busy"}, o_tx_busy, 0);
    chk({tag, "_o_tx_data"}, o_tx_data, 0);
    chk({tag, "_o_tx_start"}, o_tx_start, 0);
    chk({tag, "_o_tx_word_done"}, o_tx_word_done, 0);
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge i_clock) begin
    if (o_word_valid) begin
      if (q_word.size() == 0) unexpected("rx_word_valid");
      else begin
        mon_e = q_word.pop_front();
        chk("rx_word", o_word, mon_e.val);
        chk("rx_word_cycle", cyc, mon_e.cyc);
      end
    end
    if (o_rx_timeout) begin
      if (q_to.size() == 0) unexpected("rx_timeout");
      else begin
        mon_e = q_to.pop_front();
        chk("rx_timeout_word_kept", o_word, mon_e.val);
        chk("rx_timeout_cycle", cyc, mon_e.cyc);
      end
    end
    if (o_tx_start) begin
      if (q_tx.size() == 0) unexpected("tx_start");
      else begin
        mon_e = q_tx.pop_front();
        chk("tx_byte", o_tx_data, mon_e.val);
        chk("tx_start_cycle", cyc, (mon_e.cyc >= 0) ? mon_e.cyc : last_done_cyc);
        chk("tx_busy_at_start", o_tx_busy, 1);
      end
    end
    if (o_tx_word_done) begin
      if (q_wd.size() == 0) unexpected("tx_word_done");
      else begin
        mon_e = q_wd.pop_front();
        chk("tx_word_done_cycle", cyc, last_done_cyc);
      end
    end
  end

  // ------------------------------------------------------- UART TX responder
  initial begin : responder
    logic [7:0] b;
    int g;
    forever begin
      @(negedge i_clock);
      if (o_tx_start) begin
        b = o_tx_data;
        g = rst_gen;
        repeat (20) @(posedge i_clock);
        #1;
        if (g == rst_gen) begin
          chk("tx_data_hold", o_tx_data, b);
          i_tx_done_tick = 1'b1;
          last_done_cyc = cyc + 1;
          @(posedge i_clock);
          #1;
          i_tx_done_tick = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    repeat (50000) @(posedge i_clock);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  // ---------------------------------------------------------------- drivers
  task automatic rx_byte(input logic [7:0] b, input int gap, output int t);
    repeat (gap) @(posedge i_clock);
    #1;
    i_rx_data = b;
    i_rx_done_tick = 1'b1;
    t = cyc + 1;
    @(posedge i_clock);
    #1;
    i_rx_done_tick = 1'b0;
  endtask

  task automatic rx_word(input logic [31:0] w, input int gap);
    int t;
    for (int i = 0; i < 4; i++) rx_byte(w[8*i +: 8], gap, t);
    q_word.push_back(mk(w, t));
  endtask

  task automatic tx_send(input logic [31:0] w, output int acc);
    @(posedge i_clock);
    #1;
    i_tx_word = w;
    i_tx_word_valid = 1'b1;
    acc = cyc + 1;
    @(posedge i_clock);
    #1;
    i_tx_word_valid = 1'b0;
  endtask

  task automatic push_tx(input logic [31:0] w, input int acc, input int nb, input bit with_done);
    for (int i = 0; i < nb; i++) q_tx.push_back(mk({24'h0, w[8*i +: 8]}, (i == 0) ? acc : -1));
    if (with_done) q_wd.push_back(mk(w, -1));
  endtask

  task automatic wait_word_done(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge i_clock);
      if (o_tx_word_done) found = 1'b1;
    end
    chk(name, found, 1);
  endtask

  // ------------------------------------------------------------------ stimulus
  initial begin : main
    int t;
    int acc;
    int acc_ign;

    repeat (3) @(posedge i_clock);
    #2;
    check_all_zero("reset");
    @(negedge i_clock);
    i_reset = 1'b1;
    repeat (2) @(posedge i_clock);

    // RX pack with irregular spacing
    rx_byte(8'h78, 0, t);
    rx_byte(8'h56, 3, t);
    rx_byte(8'h34, 0, t);
    rx_byte(8'h12, 6, t);
    q_word.push_back(mk(32'h12345678, t));
    repeat (5) @(posedge i_clock);

    // Partial word dropped after the idle timeout, o_word retained
    rx_byte(8'hAA, 2, t);
    rx_byte(8'hBB, 4, t);
    q_to.push_back(mk(32'h12345678, t + TO));
    repeat (TO + 10) @(posedge i_clock);
    rx_word(32'h04030201, 2);

    // Third byte lands on the expiry edge: byte wins, no timeout strobe
    rx_byte(8'hC1, 3, t);
    rx_byte(8'hC2, 1, t);
    rx_byte(8'hC3, TO - 1, t);
    rx_byte(8'hC4, 5, t);
    q_word.push_back(mk(32'hC4C3C2C1, t));
    repeat (TO + 20) @(posedge i_clock);

    // TX word, a request during byte 2 is dropped
    tx_send(32'hDEADBEEF, acc);
    push_tx(32'hDEADBEEF, acc, 4, 1'b1);
    repeat (28) @(posedge i_clock);
    #2;
    chk("tx_busy_mid_word", o_tx_busy, 1);
    tx_send(32'h11223344, acc_ign);
    wait_word_done("tx_word1_done_seen");

    // Request raised in the word-done cycle is accepted on the next edge
    i_tx_word = 32'hA1B2C3D4;
    i_tx_word_valid = 1'b1;
    acc = cyc + 1;
    push_tx(32'hA1B2C3D4, acc, 4, 1'b1);
    @(posedge i_clock);
    #1;
    i_tx_word_valid = 1'b0;
    wait_word_done("tx_word2_done_seen");
    @(negedge i_clock);
    chk("tx_busy_after_word", o_tx_busy, 0);

    // Asynchronous reset in the middle of a TX word and a partial RX word
    repeat (5) @(posedge i_clock);
    tx_send(32'h0BADF00D, acc);
    push_tx(32'h0BADF00D, acc, 2, 1'b0);
    rx_byte(8'hE1, 1, t);
    rx_byte(8'hE2, 1, t);
    rx_byte(8'hE3, 1, t);
    while (cyc < acc + 30) @(posedge i_clock);
    #3;
    rst_gen++;
    i_reset = 1'b0;
    #1;
    check_all_zero("midreset");
    chk("midreset_tx_bytes_seen", q_tx.size(), 0);
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b1;
    repeat (30) @(posedge i_clock);

    // Fresh traffic after reset, RX and TX overlapping
    tx_send(32'hCAFEF00D, acc);
    push_tx(32'hCAFEF00D, acc, 4, 1'b1);
    rx_word(32'h55AA33CC, 1);
    wait_word_done("tx_word3_done_seen");
    @(negedge i_clock);
    chk("tx_busy_after_reset_word", o_tx_busy, 0);

    repeat (10) @(posedge i_clock);
    chk("q_word_drained", q_word.size(), 0);
    chk("q_timeout_drained", q_to.size(), 0);
    chk("q_tx_drained", q_tx.size(), 0);
    chk("q_word_done_drained", q_wd.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
